// File: rtl/i2c_pkg.sv
// Shared encodings for the write-only I2C master: FSM states, bit-time quarters
// and R/W bit values.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    AACK,
    DATA,
    DACK,
    STOP,
    DONE
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  localparam logic [6:0] I2C_TEST_ADDR = 7'h55;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period timebase: CLK_DIV down-counter plus a 2-bit quarter index,
// both restarted by clear.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      quarter <= Q0;
    end else if (clear) begin
      cnt     <= CW'(CLK_DIV - 1);
      quarter <= Q0;
    end else if (tick) begin
      cnt     <= CW'(CLK_DIV - 1);
      quarter <= quarter + 2'd1;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Write-only I2C master: START, 7-bit address + W, ACK, one data byte, ACK, STOP.
// Bus levels are decoded from state/quarter and registered, so the pins lag by one cycle.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       SCL,
  inout  wire        SDA
);

  i2c_state_e state;
  logic [7:0] shreg;
  logic [7:0] data_q;
  logic [2:0] bit_cnt;
  logic       sda_oe;
  logic       sda_s1;
  logic       sda_s2;
  logic       scl_c;
  logic       sda_oe_c;
  logic       tick;
  logic [1:0] quarter;
  logic       q_end;
  logic       ack_sample;
  logic       clear;

  assign q_end      = tick && (quarter == Q3);
  assign ack_sample = tick && (quarter == Q2);
  assign clear      = q_end || (state == IDLE) || (state == DONE);

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .tick    (tick),
    .quarter (quarter)
  );

  // Bus level per state and quarter
  always_comb begin
    scl_c    = 1'b1;
    sda_oe_c = 1'b0;
    case (state)
      START: begin
        scl_c    = (quarter != Q3);
        sda_oe_c = (quarter != Q0);
      end
      ADDR, DATA: begin
        scl_c    = (quarter == Q1) || (quarter == Q2);
        sda_oe_c = ~shreg[7];
      end
      AACK, DACK: scl_c = (quarter == Q1) || (quarter == Q2);
      STOP: begin
        scl_c    = (quarter != Q0);
        sda_oe_c = (quarter == Q0) || (quarter == Q1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      SCL    <= 1'b1;
      sda_oe <= 1'b0;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      SCL    <= scl_c;
      sda_oe <= sda_oe_c;
      sda_s1 <= SDA;
      sda_s2 <= sda_s1;
    end
  end

  assign SDA = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
      shreg   <= '0;
      data_q  <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg  <= {addr, I2C_WRITE};
            data_q <= wdata;
            nack   <= 1'b0;
            busy   <= 1'b1;
            state  <= START;
          end
        end
        START: if (q_end) state <= ADDR;
        ADDR, DATA: begin
          if (q_end) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= (state == ADDR) ? AACK : DACK;
          end
        end
        AACK: begin
          if (ack_sample && sda_s2) nack <= 1'b1;
          if (q_end) begin
            if (nack) begin
              state <= STOP;
            end else begin
              state <= DATA;
              shreg <= data_q;
            end
          end
        end
        DACK: begin
          if (ack_sample && sda_s2) nack <= 1'b1;
          if (q_end) state <= STOP;
        end
        STOP: begin
          if (q_end) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
